// File: rtl/async_fifo_if.sv
// async_fifo_if: write/read handshake bundle for async_fifo.
// Latency: none, wires only.
// Backpressure: full blocks writes; empty blocks reads.
// Ports: wr_en/wr_data (write request + word), full (write blocked),
//        rd_en (read request), rd_data (registered read word),
//        empty / has_data (occupancy flags).
interface async_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  has_data;

  // master is the traffic source/sink; slave is the FIFO itself
  modport master (
    output wr_en, wr_data, rd_en,
    input  full, rd_data, empty, has_data
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, rd_data, empty, has_data
  );
endinterface

// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO of 2**ADDR_WIDTH words with a synchronized reset release.
// Latency: 1 cycle from accepted rd_en to rd_data; flags reflect the edge just taken.
// Backpressure: writes dropped while full (incl. RESERVE headroom and reset); reads ignored while empty.
// Ports: clk, rst_n (async active-low), bus (async_fifo_if slave: wr_en, wr_data,
//        full, rd_en, rd_data, empty, has_data).
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RESERVE    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  async_fifo_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // occupancy at which writers are turned away; fits in the pointer width since DEPTH <= 2**ADDR_WIDTH
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - RESERVE);

  logic [1:0]            rst_sync;
  logic                  wr_rst;
  logic                  rd_rst;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  full;
  logic                  empty;
  logic                  wr_fire;
  logic                  rd_fire;

  // Reset asserts immediately but releases only after two rising edges,
  // so no request is honoured in the cycle rst_n happens to rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign wr_rst = rst_sync[1];
  assign rd_rst = rst_sync[1];

  // The wrap bit makes the modular difference distinguish full (DEPTH) from empty (0).
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  // Holding full during reset keeps writers off until the pointers are live.
  assign full  = wr_rst | (count >= FULL_LEVEL);

  // Permission is judged on the pre-edge flags, so a simultaneous pair
  // never lets a read pass an empty FIFO or a write pass a full one.
  assign wr_fire = bus.wr_en & ~full;
  assign rd_fire = bus.rd_en & ~empty & ~rd_rst;

  // Storage has no reset so it can map onto a RAM; the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      rd_data_q <= '0;
    end else if (rd_fire) begin
      rd_ptr    <= rd_ptr + 1'b1;
      rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.has_data = ~empty;

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed checks of async_fifo at widths 1/8/32/64 and RESERVE=2.
// All instances share clock, reset and control; sel picks the one that sees enables.
module tb_async_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel;
  logic        wr_en;
  logic        rd_en;
  logic [63:0] wr_data;
  logic        obs_full;
  logic        obs_empty;
  logic        obs_has;
  logic [63:0] obs_rd;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  async_fifo_if #(.DATA_WIDTH(8))  if_w8  ();
  async_fifo_if #(.DATA_WIDTH(1))  if_w1  ();
  async_fifo_if #(.DATA_WIDTH(32)) if_w32 ();
  async_fifo_if #(.DATA_WIDTH(64)) if_w64 ();
  async_fifo_if #(.DATA_WIDTH(8))  if_r2  ();

  assign if_w8.wr_en    = wr_en & (sel == 3'd0);
  assign if_w8.rd_en    = rd_en & (sel == 3'd0);
  assign if_w8.wr_data  = wr_data[7:0];
  assign if_w1.wr_en    = wr_en & (sel == 3'd1);
  assign if_w1.rd_en    = rd_en & (sel == 3'd1);
  assign if_w1.wr_data  = wr_data[0:0];
  assign if_w32.wr_en   = wr_en & (sel == 3'd2);
  assign if_w32.rd_en   = rd_en & (sel == 3'd2);
  assign if_w32.wr_data = wr_data[31:0];
  assign if_w64.wr_en   = wr_en & (sel == 3'd3);
  assign if_w64.rd_en   = rd_en & (sel == 3'd3);
  assign if_w64.wr_data = wr_data;
  assign if_r2.wr_en    = wr_en & (sel == 3'd4);
  assign if_r2.rd_en    = rd_en & (sel == 3'd4);
  assign if_r2.wr_data  = wr_data[7:0];

  async_fifo #(.DATA_WIDTH(8),  .ADDR_WIDTH(4), .RESERVE(0)) u_w8  (.clk(clk), .rst_n(rst_n), .bus(if_w8));
  async_fifo #(.DATA_WIDTH(1),  .ADDR_WIDTH(4), .RESERVE(0)) u_w1  (.clk(clk), .rst_n(rst_n), .bus(if_w1));
  async_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RESERVE(0)) u_w32 (.clk(clk), .rst_n(rst_n), .bus(if_w32));
  async_fifo #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .RESERVE(0)) u_w64 (.clk(clk), .rst_n(rst_n), .bus(if_w64));
  async_fifo #(.DATA_WIDTH(8),  .ADDR_WIDTH(4), .RESERVE(2)) u_r2  (.clk(clk), .rst_n(rst_n), .bus(if_r2));

  always_comb begin
    obs_full  = 1'b0;
    obs_empty = 1'b0;
    obs_has   = 1'b0;
    obs_rd    = '0;
    case (sel)
      3'd0: begin obs_full = if_w8.full;  obs_empty = if_w8.empty;  obs_has = if_w8.has_data;  obs_rd = 64'(if_w8.rd_data);  end
      3'd1: begin obs_full = if_w1.full;  obs_empty = if_w1.empty;  obs_has = if_w1.has_data;  obs_rd = 64'(if_w1.rd_data);  end
      3'd2: begin obs_full = if_w32.full; obs_empty = if_w32.empty; obs_has = if_w32.has_data; obs_rd = 64'(if_w32.rd_data); end
      3'd3: begin obs_full = if_w64.full; obs_empty = if_w64.empty; obs_has = if_w64.has_data; obs_rd = if_w64.rd_data;       end
      default: begin obs_full = if_r2.full; obs_empty = if_r2.empty; obs_has = if_r2.has_data; obs_rd = 64'(if_r2.rd_data); end
    endcase
  end

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] exp_rd;
    logic       exp_empty;
    logic       exp_full;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests (inputs change #1 after an edge), sample #1 after the next edge.
  task automatic cycle(input logic we, input logic re, input logic [63:0] d);
    wr_en   = we;
    rd_en   = re;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  function automatic logic [63:0] pat(input int s, input int i);
    case (s)
      1:       pat = 64'(i % 2);
      2:       pat = {32'h0, 16'hDEAD, 16'(i)};
      3:       pat = {32'hCAFEBABE, 16'h1234, 16'(i)};
      default: pat = 64'(i[7:0]);
    endcase
  endfunction

  // Write one word per cycle while reading the previous one back.
  task automatic stream(input int s, input int n);
    sel = 3'(s);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, pat(s, i));
      if (i > 0) check("stream_rd", obs_rd, pat(s, i - 1));
      else       check("stream_first_empty", 64'(obs_empty), 64'd0);
    end
    cycle(1'b0, 1'b1, '0);
    check("stream_last_rd", obs_rd, pat(s, n - 1));
    check("stream_end_empty", 64'(obs_empty), 64'd1);
  endtask

  logic [63:0] wide [4];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h33, 8'h22, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'h44, 8'h33, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h44, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 8'h44, 1'b1, 1'b0};

    wide[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wide[1] = 64'h0000_0000_0000_0000;
    wide[2] = 64'hAAAA_AAAA_AAAA_AAAA;
    wide[3] = 64'h5555_5555_5555_5555;

    rst_n   = 1'b1;
    sel     = 3'd0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;

    // Power-on reset: flags must take effect before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_empty", 64'(obs_empty), 64'd1);
    check("rst_has_data", 64'(obs_has), 64'd0);
    check("rst_full", 64'(obs_full), 64'd1);
    check("rst_rd_data", obs_rd, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Requests during the two release edges must be ignored.
    cycle(1'b1, 1'b1, 64'h99);
    check("rel_edge1_full", 64'(obs_full), 64'd1);
    cycle(1'b1, 1'b1, 64'h99);
    check("rel_edge2_full", 64'(obs_full), 64'd0);
    check("rel_edge2_empty", 64'(obs_empty), 64'd1);

    // Table: basic writes/reads, simultaneous ops, read of empty, latency.
    sel = 3'd0;
    for (int k = 0; k < 9; k++) begin
      cycle(vecs[k].we, vecs[k].re, 64'(vecs[k].din));
      check($sformatf("vec%0d_rd", k), obs_rd, 64'(vecs[k].exp_rd));
      check($sformatf("vec%0d_empty", k), 64'(obs_empty), 64'(vecs[k].exp_empty));
      check($sformatf("vec%0d_has", k), 64'(obs_has), 64'(!vecs[k].exp_empty));
      check($sformatf("vec%0d_full", k), 64'(obs_full), 64'(vecs[k].exp_full));
    end

    // 8-bit: 0..29 across pointer wrap.
    stream(0, 30);

    // Fill to full, dropped writes, write+read while full.
    sel = 3'd0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 64'(i));
      check($sformatf("fill%0d_full", i), 64'(obs_full), 64'(i == 15));
    end
    cycle(1'b1, 1'b0, 64'hEE);
    check("drop_full", 64'(obs_full), 64'd1);
    cycle(1'b1, 1'b1, 64'h77);
    check("full_wr_rd_rd", obs_rd, 64'd0);
    check("full_wr_rd_full", 64'(obs_full), 64'd0);
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 1'b1, '0);
      check("drain_rd", obs_rd, 64'(i));
    end
    check("drain_empty", 64'(obs_empty), 64'd1);
    cycle(1'b0, 1'b1, '0);
    check("empty_read_hold", obs_rd, 64'd15);

    // Width 1, 32 and 64 streams.
    stream(1, 20);
    stream(2, 30);
    stream(3, 30);

    // 64-bit stress patterns.
    sel = 3'd3;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, wide[i]);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, '0);
      check($sformatf("wide%0d_rd", i), obs_rd, wide[i]);
    end
    check("wide_empty", 64'(obs_empty), 64'd1);

    // RESERVE=2: full after 14 words.
    sel = 3'd4;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b0, 64'(i));
      check($sformatf("res%0d_full", i), 64'(obs_full), 64'(i == 13));
    end
    cycle(1'b1, 1'b0, 64'hEE);
    check("res_drop_full", 64'(obs_full), 64'd1);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 1'b1, '0);
      check("res_rd", obs_rd, 64'(i));
    end
    check("res_empty", 64'(obs_empty), 64'd1);

    // Reset mid-stream.
    sel = 3'd0;
    cycle(1'b1, 1'b0, 64'hA0);
    cycle(1'b1, 1'b0, 64'hA1);
    cycle(1'b1, 1'b0, 64'hA2);
    cycle(1'b0, 1'b1, '0);
    check("mid_pre_rd", obs_rd, 64'hA0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 64'(obs_empty), 64'd1);
    check("mid_rst_full", 64'(obs_full), 64'd1);
    check("mid_rst_rd", obs_rd, 64'd0);
    check("mid_rst_has", 64'(obs_has), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0);
    check("mid_rel1_full", 64'(obs_full), 64'd1);
    cycle(1'b0, 1'b0, '0);
    check("mid_rel2_full", 64'(obs_full), 64'd0);
    check("mid_rel2_empty", 64'(obs_empty), 64'd1);
    cycle(1'b1, 1'b0, 64'h5A);
    cycle(1'b1, 1'b0, 64'h5B);
    cycle(1'b0, 1'b1, '0);
    check("mid_first_rd", obs_rd, 64'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
